// File: rtl/oven_sequencer.sv
// Oven control sequencer: power-up, preheat, ready, timed bake and done.
// Owns the setpoint and bake-timer registers and runs a bang-bang heater loop
// with hysteresis around the setpoint.
//
// Ports:
//   clk, rst      clock, asynchronous active-high reset
//   power         level, 1 = oven on
//   start         pulse: begin preheat / begin bake / acknowledge done
//   cancel        pulse: abort to IDLE
//   up, down      pulses: increment / decrement the selected value
//   sel_time      in IDLE: 0 = adjust setpoint, 1 = adjust bake time
//   temp_in       measured temperature (degF)
//   heat_on       heater enable
//   setpoint      target temperature (degF)
//   bake_left     remaining bake seconds
//   at_temp       temperature within BAND of setpoint (active states only)
//   done          high while in DONE
//   state         OFF=0 IDLE=1 PREHEAT=2 READY=3 BAKE=4 DONE=5
module oven_sequencer #(
  parameter int unsigned TICK_DIV  = 50000000,
  parameter int unsigned SET_MIN   = 150,
  parameter int unsigned SET_MAX   = 550,
  parameter int unsigned SET_DEF   = 300,
  parameter int unsigned SET_STEP  = 10,
  parameter int unsigned BAKE_STEP = 60,
  parameter int unsigned BAKE_MAX  = 3600,
  parameter int unsigned BAND      = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        power,
  input  logic        start,
  input  logic        cancel,
  input  logic        up,
  input  logic        down,
  input  logic        sel_time,
  input  logic [10:0] temp_in,
  output logic        heat_on,
  output logic [10:0] setpoint,
  output logic [11:0] bake_left,
  output logic        at_temp,
  output logic        done,
  output logic [2:0]  state
);

  localparam int unsigned CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  typedef enum logic [2:0] {
    S_OFF     = 3'd0,
    S_IDLE    = 3'd1,
    S_PREHEAT = 3'd2,
    S_READY   = 3'd3,
    S_BAKE    = 3'd4,
    S_DONE    = 3'd5
  } state_t;

  state_t      state_q, state_n;
  logic [10:0] sp_q, sp_n;
  logic [11:0] bl_q, bl_n;
  logic        heat_q, heat_n;
  logic        at_q, at_n;
  logic        done_q, done_n;
  logic [CNT_W-1:0] cnt_q;
  logic        tick;

  // Saturating setpoint adjust; simultaneous up/down cancel out.
  function automatic logic [10:0] sp_adj(input logic [10:0] v, input logic inc, input logic dec);
    logic [11:0] w;
    w = {1'b0, v};
    if (inc && !dec)
      w = (w + 12'(SET_STEP) > 12'(SET_MAX)) ? 12'(SET_MAX) : w + 12'(SET_STEP);
    else if (dec && !inc)
      w = (w < 12'(SET_MIN + SET_STEP)) ? 12'(SET_MIN) : w - 12'(SET_STEP);
    return w[10:0];
  endfunction

  // Saturating bake-time adjust, clamped to [0, BAKE_MAX].
  function automatic logic [11:0] bl_adj(input logic [11:0] v, input logic inc, input logic dec);
    logic [12:0] w;
    w = {1'b0, v};
    if (inc && !dec)
      w = (w + 13'(BAKE_STEP) > 13'(BAKE_MAX)) ? 13'(BAKE_MAX) : w + 13'(BAKE_STEP);
    else if (dec && !inc)
      w = (w < 13'(BAKE_STEP)) ? 13'd0 : w - 13'(BAKE_STEP);
    return w[11:0];
  endfunction

  // Free-running 1-second tick divider.
  assign tick = (cnt_q == CNT_W'(TICK_DIV - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst)       cnt_q <= '0;
    else if (tick) cnt_q <= '0;
    else           cnt_q <= cnt_q + CNT_W'(1);
  end

  // State and datapath registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_OFF;
      sp_q    <= 11'(SET_DEF);
      bl_q    <= '0;
      heat_q  <= 1'b0;
      at_q    <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_n;
      sp_q    <= sp_n;
      bl_q    <= bl_n;
      heat_q  <= heat_n;
      at_q    <= at_n;
      done_q  <= done_n;
    end
  end

  // Next-state, register updates and heater loop.
  always_comb begin
    logic        inc, dec, act, act_n;
    logic [11:0] t12, s12, bl_tick;

    state_n = state_q;
    sp_n    = sp_q;
    bl_n    = bl_q;
    heat_n  = 1'b0;
    at_n    = 1'b0;
    done_n  = 1'b0;

    inc     = up & ~down;
    dec     = down & ~up;
    t12     = {1'b0, temp_in};
    s12     = {1'b0, sp_q};
    bl_tick = (tick && bl_q != 12'd0) ? bl_q - 12'd1 : bl_q;

    if (!power) begin
      state_n = S_OFF;
      bl_n    = '0;
    end else begin
      case (state_q)
        S_OFF: state_n = S_IDLE;
        S_IDLE: begin
          if (cancel) state_n = S_IDLE;
          else if (start && bl_q != 12'd0) state_n = S_PREHEAT;
          else if (sel_time) bl_n = bl_adj(bl_q, inc, dec);
          else sp_n = sp_adj(sp_q, inc, dec);
        end
        S_PREHEAT: begin
          if (cancel) state_n = S_IDLE;
          else begin
            if (at_q) state_n = S_READY;
            bl_n = bl_adj(bl_q, inc, dec);
          end
        end
        S_READY: begin
          if (cancel)     state_n = S_IDLE;
          else if (start) state_n = S_BAKE;
          else            bl_n = bl_adj(bl_q, inc, dec);
        end
        S_BAKE: begin
          if (cancel) begin
            state_n = S_IDLE;
            bl_n    = '0;
          end else if (bl_q == 12'd0) begin
            state_n = S_DONE;
          end else begin
            // Tick decrement lands before any user adjust in the same cycle.
            bl_n = bl_adj(bl_tick, inc, dec);
          end
        end
        S_DONE: if (start || cancel) state_n = S_IDLE;
        default: state_n = S_OFF;
      endcase
    end

    act   = (state_q == S_PREHEAT) || (state_q == S_READY) || (state_q == S_BAKE);
    act_n = (state_n == S_PREHEAT) || (state_n == S_READY) || (state_n == S_BAKE);

    // Heater and at_temp are only live while staying in an active state;
    // entering preheat forces the heater on.
    if (act_n) begin
      at_n = (t12 + 12'(BAND) >= s12) && (t12 <= s12 + 12'(BAND));
      if (!act)                       heat_n = 1'b1;
      else if (t12 + 12'(BAND) < s12) heat_n = 1'b1;
      else if (t12 >= s12)            heat_n = 1'b0;
      else                            heat_n = heat_q;
    end

    done_n = (state_n == S_DONE);
  end

  assign state     = 3'(state_q);
  assign setpoint  = sp_q;
  assign bake_left = bl_q;
  assign heat_on   = heat_q;
  assign at_temp   = at_q;
  assign done      = done_q;

endmodule

// File: tb/tb_oven_sequencer.sv
// Scoreboard bench for oven_sequencer with a 4-cycle tick.
module tb_oven_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic        power, start, cancel, up, down, sel_time;
  logic [10:0] temp_in;
  logic        heat_on, at_temp, done;
  logic [10:0] setpoint;
  logic [11:0] bake_left;
  logic [2:0]  state;

  localparam int P_UP = 0, P_DOWN = 1, P_START = 2, P_CANCEL = 3;

  oven_sequencer #(.TICK_DIV(4)) dut (
    .clk(clk), .rst(rst), .power(power), .start(start), .cancel(cancel),
    .up(up), .down(down), .sel_time(sel_time), .temp_in(temp_in),
    .heat_on(heat_on), .setpoint(setpoint), .bake_left(bake_left),
    .at_temp(at_temp), .done(done), .state(state)
  );

  always #5 clk = ~clk;

  // Cycle count since reset release; tick phase is cyc % 4.
  int cyc;
  always @(posedge clk or posedge rst) begin
    if (rst) cyc <= 0;
    else     cyc <= cyc + 1;
  end

  typedef struct {
    int          c;
    string       name;
    logic [2:0]  st;
    logic [10:0] sp;
    logic [11:0] bl;
    logic        ht;
    logic        at;
    logic        dn;
  } exp_t;

  exp_t q[$];
  int   n_chk = 0;
  int   n_fail = 0;

  task automatic expect_now(input string nm, input logic [2:0] st, input logic [10:0] sp,
                            input logic [11:0] bl, input logic ht, input logic at, input logic dn);
    exp_t e;
    e.c = cyc; e.name = nm; e.st = st; e.sp = sp; e.bl = bl; e.ht = ht; e.at = at; e.dn = dn;
    q.push_back(e);
  endtask

  // Monitor: pops every expectation due this cycle and compares on the falling edge.
  always @(negedge clk) begin
    while (q.size() > 0 && q[0].c <= cyc) begin
      exp_t e;
      e = q.pop_front();
      n_chk++;
      if (e.c < cyc) begin
        n_fail++;
        $display("FAIL %s: check missed its cycle (due %0d, now %0d)", e.name, e.c, cyc);
      end else if (state !== e.st || setpoint !== e.sp || bake_left !== e.bl ||
                   heat_on !== e.ht || at_temp !== e.at || done !== e.dn) begin
        n_fail++;
        $display("FAIL %s: got st=%0d sp=%0d bl=%0d heat=%0b at=%0b done=%0b, want st=%0d sp=%0d bl=%0d heat=%0b at=%0b done=%0b",
                 e.name, state, setpoint, bake_left, heat_on, at_temp, done,
                 e.st, e.sp, e.bl, e.ht, e.at, e.dn);
      end
    end
  end

  // Immediate check used while reset is asserted (no clock edge involved).
  task automatic check_direct(input string nm, input logic [2:0] st, input logic [10:0] sp,
                              input logic [11:0] bl, input logic ht, input logic at, input logic dn);
    n_chk++;
    if (state !== st || setpoint !== sp || bake_left !== bl ||
        heat_on !== ht || at_temp !== at || done !== dn) begin
      n_fail++;
      $display("FAIL %s: got st=%0d sp=%0d bl=%0d heat=%0b at=%0b done=%0b, want st=%0d sp=%0d bl=%0d heat=%0b at=%0b done=%0b",
               nm, state, setpoint, bake_left, heat_on, at_temp, done, st, sp, bl, ht, at, dn);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic pulse(input int which);
    case (which)
      P_UP:     up = 1'b1;
      P_DOWN:   down = 1'b1;
      P_START:  start = 1'b1;
      default:  cancel = 1'b1;
    endcase
    step(1);
    up = 1'b0; down = 1'b0; start = 1'b0; cancel = 1'b0;
  endtask

  // Park on a cycle whose tick counter is 0, so a start issued now enters
  // BAKE at phase 1 and the first decrement lands 4 cycles later.
  task automatic align();
    while (cyc % 4 != 0) step(1);
  endtask

  initial begin
    rst = 1'b1; power = 1'b0; start = 1'b0; cancel = 1'b0;
    up = 1'b0; down = 1'b0; sel_time = 1'b0; temp_in = 11'd65;
    #3;
    check_direct("reset_values", 3'd0, 11'd300, 12'd0, 1'b0, 1'b0, 1'b0);
    #9 rst = 1'b0;
    step(1);
    expect_now("off_after_reset", 3'd0, 11'd300, 12'd0, 0, 0, 0);

    // Setpoint adjust and saturation in IDLE.
    power = 1'b1; step(1);
    expect_now("power_on_idle", 3'd1, 11'd300, 12'd0, 0, 0, 0);
    pulse(P_UP);   expect_now("sp_up1", 3'd1, 11'd310, 12'd0, 0, 0, 0);
    pulse(P_UP);   expect_now("sp_up2", 3'd1, 11'd320, 12'd0, 0, 0, 0);
    pulse(P_UP);   expect_now("sp_up3", 3'd1, 11'd330, 12'd0, 0, 0, 0);
    pulse(P_DOWN); expect_now("sp_down1", 3'd1, 11'd320, 12'd0, 0, 0, 0);
    pulse(P_START); expect_now("start_no_time", 3'd1, 11'd320, 12'd0, 0, 0, 0);
    for (int i = 0; i < 30; i++) pulse(P_UP);
    expect_now("sp_sat_max", 3'd1, 11'd550, 12'd0, 0, 0, 0);
    up = 1'b1; down = 1'b1; step(1); up = 1'b0; down = 1'b0;
    expect_now("sp_up_down_both", 3'd1, 11'd550, 12'd0, 0, 0, 0);
    for (int i = 0; i < 45; i++) pulse(P_DOWN);
    expect_now("sp_sat_min", 3'd1, 11'd150, 12'd0, 0, 0, 0);
    for (int i = 0; i < 17; i++) pulse(P_UP);
    expect_now("sp_back_320", 3'd1, 11'd320, 12'd0, 0, 0, 0);

    // Preheat ramp, at_temp, READY and heater hysteresis.
    sel_time = 1'b1;
    pulse(P_UP); pulse(P_UP);
    expect_now("bl_up2", 3'd1, 11'd320, 12'd120, 0, 0, 0);
    pulse(P_START);
    expect_now("preheat_entry", 3'd2, 11'd320, 12'd120, 1, 0, 0);
    temp_in = 11'd200; step(1); expect_now("ramp_200", 3'd2, 11'd320, 12'd120, 1, 0, 0);
    temp_in = 11'd317; step(1); expect_now("ramp_317", 3'd2, 11'd320, 12'd120, 1, 0, 0);
    temp_in = 11'd318; step(1); expect_now("ramp_318_at", 3'd2, 11'd320, 12'd120, 1, 1, 0);
    step(1);                    expect_now("ready", 3'd3, 11'd320, 12'd120, 1, 1, 0);
    temp_in = 11'd321; step(1); expect_now("heat_clear_321", 3'd3, 11'd320, 12'd120, 0, 1, 0);
    temp_in = 11'd323; step(1); expect_now("above_band_323", 3'd3, 11'd320, 12'd120, 0, 0, 0);
    temp_in = 11'd317; step(1); expect_now("heat_set_317", 3'd3, 11'd320, 12'd120, 1, 0, 0);
    temp_in = 11'd319; step(1); expect_now("hold_319", 3'd3, 11'd320, 12'd120, 1, 1, 0);
    pulse(P_DOWN);              expect_now("ready_bl_down", 3'd3, 11'd320, 12'd60, 1, 1, 0);

    // Full bake from 60 s down to DONE.
    align();
    pulse(P_START);  expect_now("bake_entry", 3'd4, 11'd320, 12'd60, 1, 1, 0);
    step(3);         expect_now("bake_tick1", 3'd4, 11'd320, 12'd59, 1, 1, 0);
    step(228);       expect_now("bake_left2", 3'd4, 11'd320, 12'd2, 1, 1, 0);
    step(4);         expect_now("bake_left1", 3'd4, 11'd320, 12'd1, 1, 1, 0);
    step(3);         expect_now("bake_no_tick", 3'd4, 11'd320, 12'd1, 1, 1, 0);
    step(1);         expect_now("bake_zero", 3'd4, 11'd320, 12'd0, 1, 1, 0);
    step(1);         expect_now("done", 3'd5, 11'd320, 12'd0, 0, 0, 1);
    pulse(P_START);  expect_now("done_ack", 3'd1, 11'd320, 12'd0, 0, 0, 0);

    // Tick and down in the same cycle, then down saturating to zero.
    pulse(P_UP);     expect_now("idle_bl_60", 3'd1, 11'd320, 12'd60, 0, 0, 0);
    pulse(P_START);  expect_now("preheat_at_entry", 3'd2, 11'd320, 12'd60, 1, 1, 0);
    step(1);         expect_now("ready2", 3'd3, 11'd320, 12'd60, 1, 1, 0);
    pulse(P_UP);     expect_now("ready_bl_up", 3'd3, 11'd320, 12'd120, 1, 1, 0);
    align();
    pulse(P_START);  expect_now("bake2_entry", 3'd4, 11'd320, 12'd120, 1, 1, 0);
    step(3);         expect_now("bake2_tick1", 3'd4, 11'd320, 12'd119, 1, 1, 0);
    step(3);         expect_now("bake2_pre_tick", 3'd4, 11'd320, 12'd119, 1, 1, 0);
    down = 1'b1; step(1); expect_now("tick_and_down", 3'd4, 11'd320, 12'd58, 1, 1, 0);
    step(1); down = 1'b0; expect_now("down_sat_zero", 3'd4, 11'd320, 12'd0, 1, 1, 0);
    step(1);         expect_now("done2", 3'd5, 11'd320, 12'd0, 0, 0, 1);
    pulse(P_CANCEL); expect_now("done_cancel", 3'd1, 11'd320, 12'd0, 0, 0, 0);

    // Bake time saturation at the top, including tick+up ordering.
    for (int i = 0; i < 61; i++) pulse(P_UP);
    expect_now("bl_sat_max", 3'd1, 11'd320, 12'd3600, 0, 0, 0);
    pulse(P_START);  expect_now("preheat3", 3'd2, 11'd320, 12'd3600, 1, 1, 0);
    step(1);         expect_now("ready3", 3'd3, 11'd320, 12'd3600, 1, 1, 0);
    align();
    pulse(P_START);  expect_now("bake3_entry", 3'd4, 11'd320, 12'd3600, 1, 1, 0);
    step(3);         expect_now("bake3_tick1", 3'd4, 11'd320, 12'd3599, 1, 1, 0);
    pulse(P_UP);     expect_now("bake_up_sat", 3'd4, 11'd320, 12'd3600, 1, 1, 0);
    step(2);         expect_now("bake3_pre_tick", 3'd4, 11'd320, 12'd3600, 1, 1, 0);
    up = 1'b1; step(1); expect_now("tick_then_up", 3'd4, 11'd320, 12'd3600, 1, 1, 0);
    cancel = 1'b1; step(1); cancel = 1'b0; up = 1'b0;
    expect_now("cancel_with_up", 3'd1, 11'd320, 12'd0, 0, 0, 0);

    // Power loss during preheat.
    pulse(P_UP);     expect_now("idle_bl_60b", 3'd1, 11'd320, 12'd60, 0, 0, 0);
    temp_in = 11'd200;
    pulse(P_START);  expect_now("preheat4", 3'd2, 11'd320, 12'd60, 1, 0, 0);
    power = 1'b0; step(1); expect_now("power_off", 3'd0, 11'd320, 12'd0, 0, 0, 0);
    power = 1'b1; step(1); expect_now("power_on2", 3'd1, 11'd320, 12'd0, 0, 0, 0);

    // Asynchronous reset in the middle of a bake.
    sel_time = 1'b0;
    pulse(P_DOWN);   expect_now("sp_310", 3'd1, 11'd310, 12'd0, 0, 0, 0);
    temp_in = 11'd311; sel_time = 1'b1;
    pulse(P_UP);     expect_now("idle_bl_60c", 3'd1, 11'd310, 12'd60, 0, 0, 0);
    pulse(P_START);  expect_now("preheat5", 3'd2, 11'd310, 12'd60, 1, 1, 0);
    step(1);         expect_now("ready5_heat_off", 3'd3, 11'd310, 12'd60, 0, 1, 0);
    pulse(P_START);  expect_now("bake5_entry", 3'd4, 11'd310, 12'd60, 0, 1, 0);
    step(1);
    #2 rst = 1'b1;
    #1 check_direct("async_reset_mid_bake", 3'd0, 11'd300, 12'd0, 1'b0, 1'b0, 1'b0);
    #1 rst = 1'b0;
    step(1);         expect_now("idle_after_reset", 3'd1, 11'd300, 12'd0, 0, 0, 0);

    step(2);
    while (q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      n_chk++;
      n_fail++;
      $display("FAIL %s: expectation never checked", e.name);
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
